// File: rtl/nn_infer_scheduler.sv
// nn_infer_scheduler: paces sample pairs into the normalize->NN pipeline under
// credit and initiation-interval limits, tags returning results into a
// first-word-fall-through FIFO, and traps a hung pipeline with a watchdog.
module nn_infer_scheduler #(
   parameter int DIN_W      = 64,
   parameter int RES_W      = 18,
   parameter int FIFO_DEPTH = 16,
   parameter int II         = 1,
   parameter int TIMEOUT    = 1024,
   parameter int TAG_W      = 16
) (
   input  logic                    ap_clk,
   input  logic                    ap_rst,
   input  logic                    en,
   input  logic                    clr_err,
   input  logic [DIN_W-1:0]        s_data,
   input  logic                    s_valid,
   output logic                    s_ready,
   output logic [DIN_W-1:0]        nn_in_V,
   output logic                    nn_in_vld,
   input  logic [RES_W-1:0]        nn_out_V,
   input  logic                    nn_out_vld,
   output logic [TAG_W+RES_W-1:0]  m_data,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic                    busy,
   output logic                    err,
   output logic                    err_spurious,
   output logic [31:0]             issued_cnt,
   output logic [31:0]             done_cnt
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int IW = (II > 1) ? $clog2(II) : 1;
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam int MW = TAG_W + RES_W;

   localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);
   localparam logic [IW-1:0] II_LOAD = IW'(II - 1);
   localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_ERROR = 2'd3
   } state_t;

   state_t            state_q;
   logic [CW-1:0]     inflight_q, inflight_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [IW-1:0]     ii_q;
   logic [WW-1:0]     wd_q;
   logic [TAG_W-1:0]  tag_q;
   logic [31:0]       issued_q, done_q;
   logic              spur_q;
   logic              vld_q;
   logic [DIN_W-1:0]  din_q;
   logic [MW-1:0]     mem_q [FIFO_DEPTH];

   logic live, credit, issue, res_in, res_ok, res_spur, pop, expire, flush;

   // Credit counts both in-flight work and queued results, so a returning
   // result can never find the FIFO full.
   assign live     = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign credit   = ({1'b0, inflight_q} + {1'b0, cnt_q}) < DEPTH_C;
   assign s_ready  = (state_q == S_RUN) && credit && (ii_q == '0);
   assign issue    = s_valid && s_ready;
   assign res_in   = nn_out_vld && (state_q != S_ERROR);
   assign res_ok   = res_in && (inflight_q != '0);
   assign res_spur = res_in && (inflight_q == '0);
   assign pop      = (cnt_q != '0) && m_ready;
   assign expire   = live && (inflight_q != '0) && !nn_out_vld && (wd_q == WD_LAST);
   assign flush    = expire || (state_q == S_ERROR);

   // Control FSM: run/drain sequencing, watchdog trap and error clear.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q <= S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (en) state_q <= S_RUN;
            S_RUN: begin
               if (expire)   state_q <= S_ERROR;
               else if (!en) state_q <= S_DRAIN;
            end
            S_DRAIN: begin
               if (expire)                  state_q <= S_ERROR;
               else if (en)                 state_q <= S_RUN;
               else if (inflight_q == '0)   state_q <= S_IDLE;
            end
            S_ERROR: if (clr_err) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Next in-flight count: issue and return in the same cycle cancel out.
   always_comb begin
      inflight_d = inflight_q;
      if (flush)                inflight_d = '0;
      else if (issue && !res_ok) inflight_d = inflight_q + CW'(1);
      else if (!issue && res_ok) inflight_d = inflight_q - CW'(1);
   end

   // Next FIFO occupancy: simultaneous push and pop leave it unchanged.
   always_comb begin
      cnt_d = cnt_q;
      if (flush)               cnt_d = '0;
      else if (res_ok && !pop) cnt_d = cnt_q + CW'(1);
      else if (!res_ok && pop) cnt_d = cnt_q - CW'(1);
   end

   // In-flight counter, FIFO pointers and occupancy.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         inflight_q <= '0;
         cnt_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         inflight_q <= inflight_d;
         cnt_q      <= cnt_d;
         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (res_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)    rd_ptr_q <= rd_ptr_q + AW'(1);
         end
      end
   end

   // FIFO storage: accepted results are stored with their sequence tag.
   always_ff @(posedge ap_clk) begin
      if (res_ok) mem_q[wr_ptr_q] <= {tag_q, nn_out_V};
   end

   // Initiation-interval spacer: reloaded on every issue, counts down to 0.
   always_ff @(posedge ap_clk) begin
      if (ap_rst || flush) ii_q <= '0;
      else if (issue)      ii_q <= II_LOAD;
      else if (ii_q != '0) ii_q <= ii_q - IW'(1);
   end

   // Watchdog: ages while work is outstanding, restarts on every result.
   always_ff @(posedge ap_clk) begin
      if (ap_rst || flush)                    wd_q <= '0;
      else if (nn_out_vld || inflight_q == '0) wd_q <= '0;
      else                                     wd_q <= wd_q + WW'(1);
   end

   // Issue register: one-cycle valid pulse, data held between issues.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         vld_q <= 1'b0;
         din_q <= '0;
      end else begin
         vld_q <= issue;
         if (issue) din_q <= s_data;
      end
   end

   // Statistics, result tag and the sticky spurious-result flag survive
   // an error clear; only reset zeroes them.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         issued_q <= '0;
         done_q   <= '0;
         tag_q    <= '0;
         spur_q   <= 1'b0;
      end else begin
         if (issue) issued_q <= issued_q + 32'd1;
         if (res_ok) begin
            done_q <= done_q + 32'd1;
            tag_q  <= tag_q + TAG_W'(1);
         end
         if (res_spur) spur_q <= 1'b1;
      end
   end

   assign nn_in_V      = din_q;
   assign nn_in_vld    = vld_q;
   assign m_valid      = (cnt_q != '0);
   assign m_data       = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign busy         = (state_q != S_IDLE) || (inflight_q != '0) || (cnt_q != '0);
   assign err          = (state_q == S_ERROR);
   assign err_spurious = spur_q;
   assign issued_cnt   = issued_q;
   assign done_cnt     = done_q;

endmodule
